// File: rtl/hls_call_pkg.sv
// Shared types and default widths for the HLS call initiator.
package hls_call_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } call_state_t;

    localparam int DEF_ARG_W = 32;
    localparam int DEF_RET_W = 32;
    localparam int DEF_CYC_W = 32;

endpackage

// File: rtl/hls_call_initiator_if.sv
// Argument and result streams between the host front end and the call initiator.
// res_cycles exists only when HLS_CALL_INITIATOR_CYCLES_EN is defined.
interface hls_call_initiator_if
    import hls_call_pkg::*;
#(
    parameter int ARG_W = DEF_ARG_W,
    parameter int RET_W = DEF_RET_W
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
    , parameter int CYC_W = DEF_CYC_W
`endif
);

    logic             arg_valid;
    logic             arg_ready;
    logic [ARG_W-1:0] arg_data;
    logic             res_valid;
    logic             res_ready;
    logic [RET_W-1:0] res_data;
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
    logic [CYC_W-1:0] res_cycles;
`endif

    modport master (
        output arg_valid, arg_data, res_ready,
        input  arg_ready, res_valid, res_data
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
        , input res_cycles
`endif
    );

    modport slave (
        input  arg_valid, arg_data, res_ready,
        output arg_ready, res_valid, res_data
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
        , output res_cycles
`endif
    );

endinterface

// File: rtl/hls_call_cycle_cnt.sv
// Saturating counter with synchronous clear and enable; used for call latency
// when HLS_CALL_INITIATOR_CYCLES_EN is defined.
module hls_call_cycle_cnt
    import hls_call_pkg::*;
#(
    parameter int CYC_W = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CYC_W-1:0] sat_next
);

    logic [CYC_W-1:0] count;

    // sat_next is the count including the current enabled cycle, so a caller
    // can latch it on the same edge that ends the measured interval.
    assign sat_next = (count == {CYC_W{1'b1}}) ? count : count + CYC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sat_next;
        end
    end

endmodule

// File: rtl/hls_call_initiator.sv
// Caller-side start/finish controller for one HLS kernel instance.
// Optional call-latency measurement: define HLS_CALL_INITIATOR_CYCLES_EN.
module hls_call_initiator
    import hls_call_pkg::*;
#(
    parameter int ARG_W = DEF_ARG_W,
    parameter int RET_W = DEF_RET_W
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
    , parameter int CYC_W = DEF_CYC_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    hls_call_initiator_if.slave bus,
    output logic             callee_rst_n,
    output logic             callee_start,
    output logic [ARG_W-1:0] callee_n,
    input  logic             callee_finish,
    input  logic [RET_W-1:0] callee_ret0,
    output logic             busy,
    output logic [15:0]      calls_done
);

    call_state_t      state;
    logic             res_valid_r;
    logic [RET_W-1:0] res_data_r;
    logic             capture;

    // Decoded from state; gated by rst_n so nothing is offered while held in reset.
    assign bus.arg_ready = rst_n && (state == IDLE);
    assign busy          = (state != IDLE);
    assign callee_rst_n  = rst_n && (state != CLR);
    assign capture       = (state == WAIT) && callee_finish;

    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            callee_start <= 1'b0;
            callee_n     <= '0;
            res_valid_r  <= 1'b0;
            res_data_r   <= '0;
            calls_done   <= '0;
        end else begin
            callee_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.arg_valid) begin
                        callee_n <= bus.arg_data;
                        state    <= CLR;
                    end
                end
                CLR: begin
                    callee_start <= 1'b1;
                    state        <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // finish is a level held from the previous call until CLR,
                    // so it is only trusted once the kernel has been restarted.
                    if (callee_finish) begin
                        res_data_r  <= callee_ret0;
                        res_valid_r <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        calls_done  <= calls_done + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HLS_CALL_INITIATOR_CYCLES_EN
    logic [CYC_W-1:0] cyc_next;
    logic [CYC_W-1:0] res_cycles_r;

    hls_call_cycle_cnt #(
        .CYC_W (CYC_W)
    ) u_cycle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == START),
        .en       (state == WAIT),
        .sat_next (cyc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cycles_r <= '0;
        end else if (capture) begin
            res_cycles_r <= cyc_next;
        end
    end

    assign bus.res_cycles = res_cycles_r;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_hls_call_initiator.sv
// Directed bench for hls_call_initiator with a behavioural collatz/fixed-latency kernel.
module tb_hls_call_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        callee_rst_n, callee_start, callee_finish, busy;
    logic [31:0] callee_n, callee_ret0;
    logic [15:0] calls_done;

    int errors = 0;
    int checks = 0;
    int kmode = 0;
    int kdelay = 40;
    int exp_calls = 0;

    always #5 clk = ~clk;

    hls_call_initiator_if #(
        .ARG_W (32),
        .RET_W (32)
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
        , .CYC_W (4)
`endif
    ) bus ();

    hls_call_initiator #(
        .ARG_W (32),
        .RET_W (32)
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
        , .CYC_W (4)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .callee_rst_n  (callee_rst_n),
        .callee_start  (callee_start),
        .callee_n      (callee_n),
        .callee_finish (callee_finish),
        .callee_ret0   (callee_ret0),
        .busy          (busy),
        .calls_done    (calls_done)
    );

    // Kernel model: 0 = collatz step count, 1 = finish right after start, 2 = finish after kdelay cycles
    logic [31:0] k_x, k_cnt;
    logic        k_run;
    always @(posedge clk or negedge callee_rst_n) begin
        if (!callee_rst_n) begin
            callee_finish <= 1'b0;
            callee_ret0   <= '0;
            k_run         <= 1'b0;
            k_x           <= '0;
            k_cnt         <= '0;
        end else if (callee_start) begin
            k_x   <= callee_n;
            k_cnt <= '0;
            if (kmode == 1) begin
                callee_finish <= 1'b1;
                callee_ret0   <= 32'h1234_5678;
            end else begin
                k_run <= 1'b1;
            end
        end else if (k_run) begin
            if (kmode == 2) begin
                if (k_cnt == kdelay) begin
                    callee_finish <= 1'b1;
                    callee_ret0   <= 32'h0000_00A5;
                    k_run         <= 1'b0;
                end else begin
                    k_cnt <= k_cnt + 1;
                end
            end else if (k_x == 1) begin
                callee_finish <= 1'b1;
                callee_ret0   <= k_cnt;
                k_run         <= 1'b0;
            end else begin
                k_x   <= k_x[0] ? (3 * k_x + 1) : (k_x >> 1);
                k_cnt <= k_cnt + 1;
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic send_arg(input logic [31:0] n);
        bus.arg_valid = 1'b1;
        bus.arg_data  = n;
        @(negedge clk);
        bus.arg_valid = 1'b0;
    endtask

    task automatic wait_res(output bit got, output int waited);
        waited = 0;
        while (!bus.res_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        got = bus.res_valid;
    endtask

    // Handshake in the current cycle t; returns at the negedge of cycle t+1.
    task automatic take_res();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.arg_valid = 1'b0;
        bus.arg_data  = '0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.arg_ready, busy, bus.res_valid, callee_start, callee_rst_n} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.arg_ready, busy, bus.res_valid, callee_start, callee_rst_n});
        end
        checks++;
        if ({callee_n, bus.res_data, calls_done} !== 80'd0) begin
            errors++;
            $display("FAIL reset_data n=%0d res=%0d calls=%0d exp=0", callee_n, bus.res_data, calls_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.arg_ready, busy, callee_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL reset_release got=%b exp=101", {bus.arg_ready, busy, callee_rst_n});
        end
    endtask

    task automatic test_collatz27();
        bit got;
        int w;
        kmode = 0;
        send_arg(32'd27);
        checks++;
        if ({callee_rst_n, callee_start, busy, bus.arg_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL c27_cycle1 got=%b exp=0010", {callee_rst_n, callee_start, busy, bus.arg_ready});
        end
        @(negedge clk);
        checks++;
        if ({callee_start, callee_rst_n} !== 2'b11 || callee_n !== 32'd27) begin
            errors++;
            $display("FAIL c27_start start/rst=%b n=%0d exp=11/27", {callee_start, callee_rst_n}, callee_n);
        end
        @(negedge clk);
        checks++;
        if (callee_start !== 1'b0) begin
            errors++;
            $display("FAIL c27_single_pulse got=%b exp=0", callee_start);
        end
        wait_res(got, w);
        checks++;
        if (got !== 1'b1 || bus.res_data !== 32'd111 || callee_n !== 32'd27) begin
            errors++;
            $display("FAIL c27_result valid=%b res=%0d n=%0d exp=1/111/27", got, bus.res_data, callee_n);
        end
        take_res();
        exp_calls++;
        checks++;
        if (calls_done !== 16'(exp_calls) || bus.arg_ready !== 1'b1) begin
            errors++;
            $display("FAIL c27_done calls=%0d ready=%b exp=%0d/1", calls_done, bus.arg_ready, exp_calls);
        end
    endtask

    task automatic test_fast_finish();
        kmode = 1;
        send_arg(32'd5);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL fast_cycle3 res_valid=%b exp=0", bus.res_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fast_cycle4 valid=%b res=%h exp=1/12345678", bus.res_valid, bus.res_data);
        end
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
        checks++;
        if (bus.res_cycles !== 4'd1) begin
            errors++;
            $display("FAIL fast_cycles got=%0d exp=1", bus.res_cycles);
        end
`endif
        take_res();
        exp_calls++;
        checks++;
        if (calls_done !== 16'(exp_calls)) begin
            errors++;
            $display("FAIL fast_calls got=%0d exp=%0d", calls_done, exp_calls);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        int w;
        kmode = 1;
        send_arg(32'd9);
        wait_res(got, w);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bus.res_valid, bus.arg_ready} !== 2'b10 || bus.res_data !== 32'h1234_5678 || callee_n !== 32'd9) begin
                errors++;
                $display("FAIL bp_hold[%0d] valid/ready=%b res=%h n=%0d exp=10/12345678/9", i, {bus.res_valid, bus.arg_ready}, bus.res_data, callee_n);
            end
            bus.arg_valid = 1'b1;
            bus.arg_data  = 32'd77;
            @(negedge clk);
            bus.arg_valid = 1'b0;
        end
        take_res();
        exp_calls++;
        checks++;
        if ({bus.arg_ready, bus.res_valid, busy} !== 3'b100 || calls_done !== 16'(exp_calls) || callee_n !== 32'd9) begin
            errors++;
            $display("FAIL bp_release rdy/vld/busy=%b calls=%0d n=%0d exp=100/%0d/9", {bus.arg_ready, bus.res_valid, busy}, calls_done, callee_n, exp_calls);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        int w;
        logic [31:0] nv [2] = '{32'd1, 32'd6};
        logic [31:0] ev [2] = '{32'd0, 32'd8};
        kmode = 0;
        for (int i = 0; i < 2; i++) begin
            send_arg(nv[i]);
            checks++;
            if (callee_rst_n !== 1'b0 || bus.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_clr[%0d] rst_n=%b valid=%b exp=0/0", i, callee_rst_n, bus.res_valid);
            end
            @(negedge clk);
            checks++;
            if ({callee_start, callee_rst_n, callee_finish} !== 3'b110) begin
                errors++;
                $display("FAIL b2b_start[%0d] start/rst/fin=%b exp=110", i, {callee_start, callee_rst_n, callee_finish});
            end
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stale[%0d] res_valid=%b exp=0", i, bus.res_valid);
            end
            wait_res(got, w);
            checks++;
            if (got !== 1'b1 || bus.res_data !== ev[i]) begin
                errors++;
                $display("FAIL b2b_result[%0d] valid=%b res=%0d exp=1/%0d", i, got, bus.res_data, ev[i]);
            end
            take_res();
            exp_calls++;
            checks++;
            if (bus.arg_ready !== 1'b1 || calls_done !== 16'(exp_calls)) begin
                errors++;
                $display("FAIL b2b_idle[%0d] ready=%b calls=%0d exp=1/%0d", i, bus.arg_ready, calls_done, exp_calls);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit got;
        int w;
        kmode = 0;
        send_arg(32'd27);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.arg_ready, busy, bus.res_valid, callee_start, callee_rst_n} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_ctrl got=%b exp=00000", {bus.arg_ready, busy, bus.res_valid, callee_start, callee_rst_n});
        end
        checks++;
        if ({callee_n, bus.res_data, calls_done} !== 80'd0) begin
            errors++;
            $display("FAIL midrst_data n=%0d res=%0d calls=%0d exp=0", callee_n, bus.res_data, calls_done);
        end
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
        checks++;
        if (bus.res_cycles !== 4'd0) begin
            errors++;
            $display("FAIL midrst_cycles got=%0d exp=0", bus.res_cycles);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        exp_calls = 0;
        @(negedge clk);
        checks++;
        if (bus.arg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release ready=%b busy=%b exp=1/0", bus.arg_ready, busy);
        end
        send_arg(32'd2);
        wait_res(got, w);
        checks++;
        if (got !== 1'b1 || bus.res_data !== 32'd1) begin
            errors++;
            $display("FAIL midrst_call valid=%b res=%0d exp=1/1", got, bus.res_data);
        end
        take_res();
        exp_calls++;
        checks++;
        if (calls_done !== 16'(exp_calls)) begin
            errors++;
            $display("FAIL midrst_calls got=%0d exp=%0d", calls_done, exp_calls);
        end
    endtask

    task automatic test_stuck_kernel();
        bit got;
        int w;
        kmode  = 2;
        kdelay = 40;
        send_arg(32'd3);
        @(negedge clk);
        wait_res(got, w);
        checks++;
        if (got !== 1'b1 || bus.res_data !== 32'h0000_00A5 || w < 40) begin
            errors++;
            $display("FAIL stuck_result valid=%b res=%h waited=%0d exp=1/a5/>=40", got, bus.res_data, w);
        end
`ifdef HLS_CALL_INITIATOR_CYCLES_EN
        checks++;
        if (bus.res_cycles !== 4'd15) begin
            errors++;
            $display("FAIL stuck_cycles got=%0d exp=15", bus.res_cycles);
        end
`endif
        take_res();
        exp_calls++;
        checks++;
        if (calls_done !== 16'(exp_calls) || bus.arg_ready !== 1'b1) begin
            errors++;
            $display("FAIL stuck_done calls=%0d ready=%b exp=%0d/1", calls_done, bus.arg_ready, exp_calls);
        end
    endtask

    initial begin
        test_reset();
        test_collatz27();
        test_fast_finish();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_stuck_kernel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hls_call_initiator.md
# hls_call_initiator

Caller-side controller for a generated kernel's start/finish interface (scalar argument `n` in, scalar `ret0` out). Accepts argument words on a valid/ready stream and soft-resets the kernel. It then pulses `start`, holds the argument stable, and waits for `finish`. The captured return value is delivered on a valid/ready result stream. It sits between a host/AXI-lite front end and one kernel instance, with one call outstanding at a time.

## Interface
Parameters:
- `ARG_W`, 32, kernel argument width
- `RET_W`, 32, kernel return width
- `CYC_W`, 32, width of call-latency counter (only with macro)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; **asynchronous, active-low**
- `arg_valid`  in  1  argument offered
- `arg_ready`  out  1  block can accept argument
- `arg_data`  in  ARG_W  argument value
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  RET_W  captured kernel return
- `res_cycles`  out  CYC_W  cycles from `start` to `finish` (macro only)
- `callee_rst_n`  out  1  kernel reset; low while `rst_n` low and for one CLR cycle
- `callee_start`  out  1  one-cycle start pulse to kernel
- `callee_n`  out  ARG_W  argument to kernel, registered
- `callee_finish`  in  1  kernel done; level, held until kernel reset
- `callee_ret0`  in  RET_W  kernel return, valid while `callee_finish`=1
- `busy`  out  1  high in any state but IDLE
- `calls_done`  out  16  completed-call counter, wraps at 65535→0

## Operation
- FSM states: IDLE, CLR, START, WAIT, RESP.
- IDLE: `arg_ready`=1. On `arg_valid&&arg_ready`, register `arg_data` into `callee_n` and go to CLR.
- CLR: `callee_rst_n`=0 for exactly one cycle. This clears the level `finish` left from the previous call. Go to START.
- START: `callee_start`=1 for exactly one cycle. Go to WAIT.
- WAIT: on first cycle with `callee_finish`=1, capture `callee_ret0` into `res_data` and go to RESP. Otherwise stay in WAIT indefinitely; there is no timeout.
- RESP: `res_valid`=1. `res_data` is held stable until `res_valid&&res_ready`. On that handshake, increment `calls_done` and go to IDLE.
- `callee_n` is held stable from CLR through RESP. It is changed only by an IDLE acceptance.
- `callee_finish` is ignored in IDLE, CLR, START and RESP.
- `arg_ready` is low in every state but IDLE. A result handshake and a new argument are never accepted in the same cycle.
- `callee_rst_n` = `rst_n` AND (state≠CLR). The kernel is reset whenever the block is reset.
- Reset (asynchronous, any state, including mid-WAIT): the state goes to IDLE. `res_valid`, `callee_start`, `busy`, `res_data`, `callee_n`, `calls_done` and `res_cycles` all go to 0. `callee_rst_n` goes to 0. A pending call is lost.
- After `rst_n` rises, `arg_ready`=1 from the first clock edge.

## Timing
- Acceptance edge = cycle 0.
- Cycle 1: CLR, with `callee_rst_n` low.
- Cycle 2: START, with `callee_start` high.
- Cycle 3 onward: WAIT.
- If `callee_finish` is first high in cycle k, then `res_valid`=1 from cycle k+1.
- Minimum turnaround, with a kernel finishing in cycle 3: `res_valid` at cycle 4.
- After the result handshake in cycle t, the block is in IDLE in cycle t+1. The next argument can be accepted then.
- `res_valid` is never deasserted without a handshake.
- All outputs are registered except `arg_ready`, `busy` and `callee_rst_n`, which are decoded from the state register.

## Configuration
- `HLS_CALL_INITIATOR_CYCLES_EN` defined:
  - A CYC_W counter clears on START and increments each WAIT cycle, saturating at all-ones.
  - Its value is latched into `res_cycles` on capture.
  - Minimum value is 1 (finish in the first WAIT cycle).
- `HLS_CALL_INITIATOR_CYCLES_EN` undefined:
  - The `res_cycles` port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Package `hls_call_pkg`:
  - state enum `call_state_t` (IDLE, CLR, START, WAIT, RESP)
  - default width localparams for ARG_W, RET_W and CYC_W
- One sub-module: `hls_call_cycle_cnt`, a saturating counter with clear/enable. It is instantiated only under the macro.

## Test plan
- Reset, then n=27 with a behavioural collatz kernel: `callee_start` one pulse at cycle 2, `callee_n`=27 held, `res_data`=111, `calls_done`=1.
- Kernel finishing in the first WAIT cycle: `res_valid` at cycle 4; with macro, `res_cycles`=1.
- `res_ready` held low 10 cycles after `res_valid`: `res_data` stable, `arg_ready`=0 throughout. Then handshake; `arg_ready`=1 the next cycle.
- Two calls back to back (n=1, then n=6): `callee_rst_n` low one cycle before each start, stale `finish` is not re-captured, and results are 0 then 8.
- `rst_n` asserted mid-WAIT: all outputs are zero immediately (asynchronous). After release, `arg_ready`=1 and a new call n=2 returns 1.
- Stuck kernel with macro and CYC_W=4: `res_cycles` saturates at 15 once `finish` arrives after 40 cycles.
